// File: rtl/icache_line_fill.sv
// rtl/icache_line_fill.sv - 8-word instruction cache line fill engine over a req/ack word port
module icache_line_fill #(
    parameter int TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        miss,
    input  logic [31:0] miss_addr,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] w0,
    output logic [31:0] w1,
    output logic [31:0] w2,
    output logic [31:0] w3,
    output logic [31:0] w4,
    output logic [31:0] w5,
    output logic [31:0] w6,
    output logic [31:0] w7,
    output logic [31:0] fill_addr,
    output logic        fill_done,
    output logic        fill_err,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    logic [2:0]  cnt;
    logic [7:0]  wcnt;
    logic [26:0] base;
    logic [31:0] line [8];

    // Word address is a concatenation so it can never carry out of the line.
    assign mem_addr  = {base, cnt, 2'b00};
    assign fill_addr = {base, 5'b00000};
    assign busy      = (state != IDLE) | miss;

    assign w0 = line[0];
    assign w1 = line[1];
    assign w2 = line[2];
    assign w3 = line[3];
    assign w4 = line[4];
    assign w5 = line[5];
    assign w6 = line[6];
    assign w7 = line[7];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            cnt       <= 3'd0;
            wcnt      <= 8'd0;
            base      <= 27'd0;
            mem_req   <= 1'b0;
            fill_done <= 1'b0;
            fill_err  <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                line[i] <= 32'd0;
            end
        end else begin
            fill_done <= 1'b0;
            fill_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (miss) begin
                        base    <= miss_addr[31:5];
                        cnt     <= 3'd0;
                        wcnt    <= 8'd0;
                        mem_req <= 1'b1;
                        state   <= FETCH;
                    end
                end
                FETCH: begin
                    // A redirect wins over a same-cycle ack; that word is dropped.
                    if (flush) begin
                        mem_req <= 1'b0;
                        state   <= IDLE;
                    end else if (mem_ack) begin
                        line[cnt] <= mem_rdata;
                        cnt       <= cnt + 3'd1;
                        wcnt      <= 8'd0;
                        if (cnt == 3'd7) begin
                            mem_req   <= 1'b0;
                            fill_done <= 1'b1;
                            state     <= DONE;
                        end
                    end else begin
                        wcnt <= wcnt + 8'd1;
                        if (wcnt == WAIT_LAST) begin
                            mem_req  <= 1'b0;
                            fill_err <= 1'b1;
                            state    <= IDLE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
